// File: rtl/msg_send_pkg.sv
// Shared types and defaults for the UART console message sender.
// Holds the FSM state encoding, the default bus addresses and the character width.
package msg_send_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int          CHAR_W          = 8;
   localparam logic [31:0] DEF_STATUS_ADDR = 32'h3000_0004;
   localparam logic [31:0] DEF_BUF_BASE    = 32'h3000_1000;

endpackage

// File: rtl/msg_buf.sv
// Character buffer for msg_send: DEPTH x CHAR_W register file.
// Synchronous write, combinational read by index, synchronous clear on reset.
module msg_buf
   import msg_send_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [CHAR_W-1:0] wdata,
   input  logic [IDX_W-1:0]  raddr,
   output logic [CHAR_W-1:0] rdata
);

   logic [CHAR_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/msg_send.sv
// CPU-loadable message transmitter snooping the ex-to-mem bus.
// Emits one buffered character per idle-UART status poll, with repeat, abort and error reporting.
module msg_send
   import msg_send_pkg::*;
#(
   parameter int          DEPTH       = 16,
   parameter logic [31:0] STATUS_ADDR = DEF_STATUS_ADDR,
   parameter int          BUSY_BIT    = 0,
   parameter logic [31:0] BUF_BASE    = DEF_BUF_BASE,
   parameter int          LEN_W       = $clog2(DEPTH+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic [7:0]       repeat_i,
   input  logic             mem_req_i,
   input  logic             mem_we_i,
   input  logic [31:0]      mem_addr_i,
   input  logic [31:0]      mem_wdata_i,
   input  logic [31:0]      mem_rdata_i,
   output logic [31:0]      char_o,
   output logic             busy_o,
   output logic             ready_o,
   output logic             done_o,
   output logic             err_o
);

   localparam int          IDX_W     = $clog2(DEPTH);
   localparam logic [31:0] WIN_BYTES = 32'(4 * DEPTH);

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic [7:0]         pass;
   logic [LEN_W-1:0]   len_q;
   logic [7:0]         rep_q;
   logic [31:0]        offset;
   logic               in_win;
   logic               buf_we;
   logic               poll;
   logic               len_ok;
   logic               last_idx;
   logic [CHAR_W-1:0]  rd_char;
   logic               unused_bits;

   // Bus decode: the window compare uses the full offset, so wrap-around below BUF_BASE is rejected.
   assign offset   = mem_addr_i - BUF_BASE;
   assign in_win   = (mem_addr_i >= BUF_BASE) && (offset < WIN_BYTES) && (mem_addr_i[1:0] == 2'b00);
   assign buf_we   = mem_req_i & mem_we_i & in_win & ~busy_o;
   assign poll     = mem_req_i & ~mem_we_i & (mem_addr_i == STATUS_ADDR) & ~mem_rdata_i[BUSY_BIT];
   assign len_ok   = (len_i != '0) && (len_i <= LEN_W'(DEPTH));
   assign last_idx = (LEN_W'(idx) == (len_q - LEN_W'(1)));

   assign unused_bits = ^{mem_wdata_i[31:CHAR_W], mem_rdata_i, offset[1:0]};

   msg_buf #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_buf (
      .clk   (clk),
      .rst   (rst),
      .we    (buf_we),
      .waddr (offset[IDX_W+1:2]),
      .wdata (mem_wdata_i[CHAR_W-1:0]),
      .raddr (idx),
      .rdata (rd_char)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         idx     <= '0;
         pass    <= '0;
         len_q   <= '0;
         rep_q   <= '0;
         char_o  <= '0;
         busy_o  <= 1'b0;
         ready_o <= 1'b0;
         done_o  <= 1'b0;
         err_o   <= 1'b0;
      end else begin
         ready_o <= 1'b0;
         done_o  <= 1'b0;
         err_o   <= 1'b0;
         case (state)
            IDLE: begin
               // An abort arriving with a start suppresses the start entirely.
               if (!abort_i && start_i) begin
                  if (len_ok) begin
                     len_q  <= len_i;
                     rep_q  <= repeat_i;
                     idx    <= '0;
                     pass   <= '0;
                     state  <= SEND;
                     busy_o <= 1'b1;
                  end else begin
                     err_o <= 1'b1;
                  end
               end
            end
            SEND: begin
               if (abort_i) begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end else if (poll) begin
                  char_o  <= 32'(rd_char);
                  ready_o <= 1'b1;
                  if (!last_idx) begin
                     idx <= idx + IDX_W'(1);
                  end else if (pass != rep_q) begin
                     idx  <= '0;
                     pass <= pass + 8'd1;
                  end else begin
                     state  <= DONE;
                     done_o <= 1'b1;
                  end
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_msg_send.sv
// Directed bench for msg_send: per-cycle vector table plus hand-written corner sequences.
module tb_msg_send;

   localparam logic [31:0] STATUS = 32'h3000_0004;
   localparam logic [31:0] BASE   = 32'h3000_1000;

   logic        clk = 1'b0;
   logic        rst, start_i, abort_i, mem_req_i, mem_we_i;
   logic [4:0]  len_i;
   logic [7:0]  repeat_i;
   logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_i;
   logic [31:0] char_o;
   logic        busy_o, ready_o, done_o, err_o;

   int n_vec = 0;
   int n_bad = 0;

   msg_send dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start_i),
      .abort_i     (abort_i),
      .len_i       (len_i),
      .repeat_i    (repeat_i),
      .mem_req_i   (mem_req_i),
      .mem_we_i    (mem_we_i),
      .mem_addr_i  (mem_addr_i),
      .mem_wdata_i (mem_wdata_i),
      .mem_rdata_i (mem_rdata_i),
      .char_o      (char_o),
      .busy_o      (busy_o),
      .ready_o     (ready_o),
      .done_o      (done_o),
      .err_o       (err_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        rst;
      logic        start;
      logic        abort;
      logic [4:0]  len;
      logic [7:0]  rep;
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        e_ready;
      logic        e_done;
      logic        e_busy;
      logic        e_err;
      logic [31:0] e_char;
   } vec_t;

   function automatic vec_t nop();
      vec_t v;
      v = '0;
      return v;
   endfunction

   function automatic vec_t rs();
      vec_t v = nop();
      v.rst = 1'b1;
      return v;
   endfunction

   function automatic vec_t wr(input logic [31:0] a, input logic [31:0] d);
      vec_t v = nop();
      v.req = 1'b1; v.we = 1'b1; v.addr = a; v.wdata = d;
      return v;
   endfunction

   function automatic vec_t pl(input logic we, input logic [31:0] a, input logic [31:0] rd);
      vec_t v = nop();
      v.req = 1'b1; v.we = we; v.addr = a; v.rdata = rd;
      return v;
   endfunction

   function automatic vec_t ok();
      return pl(1'b0, STATUS, 32'h0);
   endfunction

   function automatic vec_t st(input logic [4:0] l, input logic [7:0] r);
      vec_t v = nop();
      v.start = 1'b1; v.len = l; v.rep = r;
      return v;
   endfunction

   function automatic vec_t ab();
      vec_t v = nop();
      v.abort = 1'b1;
      return v;
   endfunction

   function automatic vec_t ex(input vec_t vi, input logic r, input logic d, input logic b,
                               input logic e, input logic [31:0] c);
      vec_t v = vi;
      v.e_ready = r; v.e_done = d; v.e_busy = b; v.e_err = e; v.e_char = c;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input string nm);
      @(negedge clk);
      rst         = v.rst;
      start_i     = v.start;
      abort_i     = v.abort;
      len_i       = v.len;
      repeat_i    = v.rep;
      mem_req_i   = v.req;
      mem_we_i    = v.we;
      mem_addr_i  = v.addr;
      mem_wdata_i = v.wdata;
      mem_rdata_i = v.rdata;
      @(posedge clk);
      #1;
      chk({nm, ".ready"}, 32'(ready_o), 32'(v.e_ready));
      chk({nm, ".done"},  32'(done_o),  32'(v.e_done));
      chk({nm, ".busy"},  32'(busy_o),  32'(v.e_busy));
      chk({nm, ".err"},   32'(err_o),   32'(v.e_err));
      chk({nm, ".char"},  char_o,       v.e_char);
   endtask

   vec_t tbl[$];

   initial begin
      rst = 1'b1; start_i = 0; abort_i = 0; len_i = 0; repeat_i = 0;
      mem_req_i = 0; mem_we_i = 0; mem_addr_i = 0; mem_wdata_i = 0; mem_rdata_i = 0;

      tbl.push_back(ex(rs(), 0, 0, 0, 0, 32'h00));
      // Load "2023", send once; interleave polls that must not match.
      tbl.push_back(ex(wr(BASE + 0,  32'hFFFF_FF32), 0, 0, 0, 0, 32'h00));
      tbl.push_back(ex(wr(BASE + 4,  32'h0000_0030), 0, 0, 0, 0, 32'h00));
      tbl.push_back(ex(wr(BASE + 8,  32'h0000_0032), 0, 0, 0, 0, 32'h00));
      tbl.push_back(ex(wr(BASE + 12, 32'h0000_0033), 0, 0, 0, 0, 32'h00));
      tbl.push_back(ex(st(5'd4, 8'd0),             0, 0, 1, 0, 32'h00));
      tbl.push_back(ex(ok(),                        1, 0, 1, 0, 32'h32));
      tbl.push_back(ex(pl(1'b0, STATUS, 32'h1),     0, 0, 1, 0, 32'h32));
      tbl.push_back(ex(pl(1'b1, STATUS, 32'h0),     0, 0, 1, 0, 32'h32));
      tbl.push_back(ex(pl(1'b0, 32'h3000_0008, 0),  0, 0, 1, 0, 32'h32));
      tbl.push_back(ex(nop(),                       0, 0, 1, 0, 32'h32));
      tbl.push_back(ex(ok(),                        1, 0, 1, 0, 32'h30));
      tbl.push_back(ex(ok(),                        1, 0, 1, 0, 32'h32));
      tbl.push_back(ex(ok(),                        1, 1, 1, 0, 32'h33));
      tbl.push_back(ex(nop(),                       0, 0, 0, 0, 32'h33));
      // Rejected lengths.
      tbl.push_back(ex(st(5'd0, 8'd0),              0, 0, 0, 1, 32'h33));
      tbl.push_back(ex(st(5'd17, 8'd0),             0, 0, 0, 1, 32'h33));
      tbl.push_back(ex(nop(),                       0, 0, 0, 0, 32'h33));
      // "AB" with two repeats.
      tbl.push_back(ex(wr(BASE + 0, 32'h41),        0, 0, 0, 0, 32'h33));
      tbl.push_back(ex(wr(BASE + 4, 32'h42),        0, 0, 0, 0, 32'h33));
      tbl.push_back(ex(st(5'd2, 8'd2),              0, 0, 1, 0, 32'h33));
      tbl.push_back(ex(ok(),                        1, 0, 1, 0, 32'h41));
      tbl.push_back(ex(ok(),                        1, 0, 1, 0, 32'h42));
      tbl.push_back(ex(ok(),                        1, 0, 1, 0, 32'h41));
      tbl.push_back(ex(ok(),                        1, 0, 1, 0, 32'h42));
      tbl.push_back(ex(ok(),                        1, 0, 1, 0, 32'h41));
      tbl.push_back(ex(ok(),                        1, 1, 1, 0, 32'h42));
      tbl.push_back(ex(ok(),                        0, 0, 0, 0, 32'h42));

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i], $sformatf("vec%0d", i));
      end

      // Full-depth message.
      for (int i = 0; i < 16; i++) begin
         apply(ex(wr(BASE + 32'(4 * i), 32'(8'h60 + i)), 0, 0, 0, 0, 32'h42), $sformatf("fill%0d", i));
      end
      apply(ex(st(5'd16, 8'd0), 0, 0, 1, 0, 32'h42), "full_start");
      for (int i = 0; i < 16; i++) begin
         apply(ex(ok(), 1, (i == 15), 1, 0, 32'(8'h60 + i)), $sformatf("full%0d", i));
      end
      apply(ex(nop(), 0, 0, 0, 0, 32'h6f), "full_end");

      // Abort after two of four, then start+abort together.
      apply(ex(st(5'd4, 8'd0), 0, 0, 1, 0, 32'h6f), "ab_start");
      apply(ex(ok(), 1, 0, 1, 0, 32'h60), "ab_c0");
      apply(ex(ok(), 1, 0, 1, 0, 32'h61), "ab_c1");
      apply(ex(ab(), 0, 0, 0, 0, 32'h61), "ab_abort");
      apply(ex(ok(), 0, 0, 0, 0, 32'h61), "ab_after");
      begin
         vec_t v = st(5'd4, 8'd0);
         v.abort = 1'b1;
         apply(ex(v, 0, 0, 0, 0, 32'h61), "start_abort");
      end
      apply(ex(nop(), 0, 0, 0, 0, 32'h61), "start_abort_idle");

      // Buffer writes while busy and misaligned writes are dropped.
      apply(ex(st(5'd1, 8'd0), 0, 0, 1, 0, 32'h61), "wb_start");
      apply(ex(wr(BASE, 32'h99), 0, 0, 1, 0, 32'h61), "wb_write");
      apply(ex(ok(), 1, 1, 1, 0, 32'h60), "wb_c0");
      apply(ex(nop(), 0, 0, 0, 0, 32'h60), "wb_idle");
      apply(ex(wr(BASE + 1, 32'h77), 0, 0, 0, 0, 32'h60), "wb_misalign");
      apply(ex(st(5'd1, 8'd0), 0, 0, 1, 0, 32'h60), "wb_start2");
      apply(ex(ok(), 1, 1, 1, 0, 32'h60), "wb_c1");
      apply(ex(nop(), 0, 0, 0, 0, 32'h60), "wb_idle2");

      // Reset mid-transfer clears outputs and buffer.
      apply(ex(st(5'd4, 8'd0), 0, 0, 1, 0, 32'h60), "rs_start");
      apply(ex(ok(), 1, 0, 1, 0, 32'h60), "rs_c0");
      apply(ex(rs(), 0, 0, 0, 0, 32'h00), "rs_reset");
      apply(ex(st(5'd4, 8'd0), 0, 0, 1, 0, 32'h00), "rs_start2");
      for (int i = 0; i < 4; i++) begin
         apply(ex(ok(), 1, (i == 3), 1, 0, 32'h00), $sformatf("rs_z%0d", i));
      end
      apply(ex(nop(), 0, 0, 0, 0, 32'h00), "rs_end");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
